// File: rtl/wb_s2mm_writer.sv
// wb_s2mm_writer: AXI-Stream to Wishbone DMA writer with CPU register port; S2MM_TLAST_EN enables tlast-terminated transfers
module wb_s2mm_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_stb_i,
  input  logic        cfg_cyc_i,
  input  logic        cfg_we_i,
  input  logic [3:0]  cfg_adr_i,
  input  logic [31:0] cfg_dat_i,
  output logic        cfg_ack_o,
  output logic [31:0] cfg_dat_o,
  input  logic        s_tvalid,
  input  logic        s_tlast,
  input  logic [31:0] s_tdata,
  output logic        s_tready,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic        m_ack_i,
  output logic        irq
);
  localparam int AW = $clog2(FIFO_DEPTH);
`ifdef S2MM_TLAST_EN
  localparam int DW = 33;
`else
  localparam int DW = 32;
`endif
  typedef enum logic [1:0] {IDLE, RUN, WR, DONE} state_t;
  state_t state_q, state_d;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic [31:0] dst_q, addr_q, rdat_q, rdat;
  logic [LEN_W-1:0] len_q, wcnt_q, acnt_q;
  logic done_q, ie_q, last_seen_q, ack_q;
  logic req, cfg_wr, ctrl_wr, busy, start, empty, full, push, pop, head_last, tl_push, fin;
  logic [DW-1:0] head, entry;
  logic unused_bits;
  assign unused_bits = &{1'b0, cfg_adr_i[1:0], s_tlast};
  assign req = cfg_stb_i && cfg_cyc_i && !ack_q;
  assign cfg_wr = req && cfg_we_i;
  assign ctrl_wr = cfg_wr && cfg_adr_i[3:2] == 2'd0;
  assign busy = state_q != IDLE;
  assign start = ctrl_wr && cfg_dat_i[0] && !busy;
  assign empty = wp_q == rp_q;
  assign full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign head = mem_q[rp_q[AW-1:0]];
  assign s_tready = (state_q == RUN || state_q == WR) && !full && (acnt_q < len_q) && !last_seen_q;
  assign push = s_tvalid && s_tready;
  assign pop = state_q == WR && m_ack_i;
`ifdef S2MM_TLAST_EN
  assign entry = {s_tlast, s_tdata};
  assign head_last = head[DW-1];
  assign tl_push = push && s_tlast;
`else
  assign entry = s_tdata;
  assign head_last = 1'b0;
  assign tl_push = 1'b0;
`endif
  assign fin = (wcnt_q + LEN_W'(1) == len_q) || head_last;
  assign rdat = cfg_adr_i[3:2] == 2'd0 ? {28'd0, ie_q, busy, done_q, 1'b0}
              : cfg_adr_i[3:2] == 2'd1 ? dst_q
              : cfg_adr_i[3:2] == 2'd2 ? 32'(len_q) : 32'(wcnt_q);
  assign cfg_ack_o = ack_q;
  assign cfg_dat_o = rdat_q;
  assign m_sel_o = 4'hF;
  assign irq = done_q && ie_q;
  // next state and master outputs; outputs are only non-zero while a write beat is held in WR
  always_comb begin
    state_d = state_q;
    m_stb_o = 1'b0;
    m_cyc_o = 1'b0;
    m_we_o = 1'b0;
    m_adr_o = '0;
    m_dat_o = '0;
    case (state_q)
      IDLE: state_d = start ? (len_q == '0 ? DONE : RUN) : IDLE;
      RUN: state_d = empty ? RUN : WR;
      WR: begin
        m_stb_o = 1'b1;
        m_cyc_o = 1'b1;
        m_we_o = 1'b1;
        m_adr_o = addr_q;
        m_dat_o = head[31:0];
        state_d = m_ack_i ? (fin ? DONE : RUN) : WR;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // slave port: single-cycle ack, never back-to-back, with read data captured at the request
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      rdat_q <= '0;
    end else begin
      ack_q <= req;
      if (req) rdat_q <= rdat;
    end
  end
  // CPU registers; DST and LEN are frozen during a transfer, hardware DONE set beats a W1C
  always_ff @(posedge clk) begin
    if (rst) begin
      dst_q <= '0;
      len_q <= '0;
      ie_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      if (cfg_wr && cfg_adr_i[3:2] == 2'd1 && !busy) dst_q <= {cfg_dat_i[31:2], 2'b00};
      if (cfg_wr && cfg_adr_i[3:2] == 2'd2 && !busy) len_q <= cfg_dat_i[LEN_W-1:0];
      if (ctrl_wr) ie_q <= cfg_dat_i[3];
      done_q <= state_q == DONE || (done_q && !(ctrl_wr && cfg_dat_i[1]));
    end
  end
  // transfer bookkeeping: write address, words written (COUNT), words accepted, tlast seen
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      wcnt_q <= '0;
      acnt_q <= '0;
      last_seen_q <= 1'b0;
    end else if (start) begin
      addr_q <= dst_q;
      wcnt_q <= '0;
      acnt_q <= '0;
      last_seen_q <= 1'b0;
    end else begin
      if (push) acnt_q <= acnt_q + LEN_W'(1);
      if (tl_push) last_seen_q <= 1'b1;
      if (pop) begin
        addr_q <= addr_q + 32'd4;
        wcnt_q <= wcnt_q + LEN_W'(1);
      end
    end
  end
  // FIFO pointers with wrap bit to tell full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + 1'b1;
      if (pop) rp_q <= rp_q + 1'b1;
    end
  end
  // FIFO storage
  always_ff @(posedge clk) if (push) mem_q[wp_q[AW-1:0]] <= entry;
endmodule
